// File: rtl/sram_access_controller.sv
// Splits each 32-bit MEM-stage load/store into two halfword phases on a 16-bit async SRAM.
// Optional stall counter port enabled by defining SRAM_CTRL_STALL_CNT_EN.
module sram_access_controller #(
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rd_en_i,
  input  logic               wr_en_i,
  input  logic [31:0]        address_i,
  input  logic [31:0]        write_data_i,
  output logic [31:0]        read_data_o,
  output logic               ready_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_dq_out_o,
  output logic               sram_dq_oe_o,
  input  logic [15:0]        sram_dq_in_i,
  output logic               sram_we_n_o,
  output logic               sram_oe_n_o
`ifdef SRAM_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]        stall_count_o
`endif
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES);

  // With no wait states the write strobe would never be asserted.
  if (WAIT_CYCLES == 0) begin : gen_bad_wait
    $error("sram_access_controller: WAIT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        offset;
  logic               last;
  logic               unused_offset;

  assign offset        = address_i - BASE_ADDR;
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign last          = (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (rd_en_i || wr_en_i) begin
          state_d = StLo;
          cnt_d   = '0;
          wr_d    = wr_en_i;  // simultaneous rd/wr is a store
          word_d  = offset[SRAM_AW:2];
          wdata_d = write_data_i;
        end
      end
      StLo: begin
        if (last) begin
          state_d = StHi;
          cnt_d   = '0;
          if (!wr_q) rdata_d[15:0] = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHi: begin
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!wr_q) rdata_d[31:16] = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o       = 1'b0;
    sram_addr_o   = '0;
    sram_dq_out_o = '0;
    sram_dq_oe_o  = 1'b0;
    sram_we_n_o   = 1'b1;
    sram_oe_n_o   = 1'b1;
    unique case (state_q)
      StIdle: ready_o = !(rd_en_i || wr_en_i);
      StLo, StHi: begin
        sram_addr_o = {word_q, state_q == StHi};
        if (wr_q) begin
          sram_dq_oe_o  = 1'b1;
          sram_dq_out_o = (state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0];
          // Release the strobe on the final phase cycle to give data hold time.
          sram_we_n_o   = last;
        end else begin
          sram_oe_n_o = 1'b0;
        end
      end
      StDone: ready_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  assign read_data_o = rdata_q;

`ifdef SRAM_CTRL_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!ready_o && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_count_o = stall_q;
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_sram_access_controller.sv
// Scoreboard bench for sram_access_controller with a behavioural 16-bit SRAM model.
module tb_sram_access_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;
`ifdef SRAM_CTRL_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  sram_access_controller dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_en_i      (rd_en),
    .wr_en_i      (wr_en),
    .address_i    (address),
    .write_data_i (write_data),
    .read_data_o  (read_data),
    .ready_o      (ready),
    .sram_addr_o  (sram_addr),
    .sram_dq_out_o(sram_dq_out),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_dq_in_i (sram_dq_in),
    .sram_we_n_o  (sram_we_n),
    .sram_oe_n_o  (sram_oe_n)
`ifdef SRAM_CTRL_STALL_CNT_EN
    ,
    .stall_count_o(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model (64 halfwords, address aliased) with a bench-side preload port.
  logic [15:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    logic [17:0] a_lo;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: measures each access while ready=0 and scores it when ready returns.
  int          low_run = 0;
  int          we_cnt = 0;
  int          oe_cnt = 0;
  bit          seen = 0;
  logic [17:0] a0 = '0;
  logic [17:0] a1 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 0; we_cnt = 0; oe_cnt = 0; seen = 0;
    end else if (!ready) begin
      low_run++;
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_oe_n || sram_dq_oe) begin
        if (!seen) a0 = sram_addr;
        seen = 1;
        a1 = sram_addr;
      end
    end else if (low_run > 0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got completion, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", 32'(low_run), 32'd7);
        chk("we_cycles", 32'(we_cnt), e.is_wr ? 32'd4 : 32'd0);
        chk("oe_cycles", 32'(oe_cnt), e.is_wr ? 32'd0 : 32'd6);
        chk("addr_lo", 32'(a0), 32'(e.a_lo));
        chk("addr_hi", 32'(a1), 32'(e.a_lo | 18'd1));
        if (e.is_wr) begin
          chk("sram_lo", 32'(mem[e.a_lo[5:0]]), 32'(e.data[15:0]));
          chk("sram_hi", 32'(mem[e.a_lo[5:0] | 6'd1]), 32'(e.data[31:16]));
        end else begin
          chk("read_data", read_data, e.data);
        end
      end
      done_cnt++;
      low_run = 0; we_cnt = 0; oe_cnt = 0; seen = 0;
    end
  end

  task automatic preload(input int idx, input logic [15:0] val);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = 6'(idx); pre_data = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push(input logic w, input logic [31:0] d, input logic [17:0] a);
    exp_t e;
    e.is_wr = w; e.data = d; e.a_lo = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      $display("FAIL timeout: ready=%b after %0d cycles, expected 1", ready, n);
    end
  endtask

  task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int accesses);
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    for (int i = 0; i < accesses; i++) wait_done();
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int done_ref;
`ifdef SRAM_CTRL_STALL_CNT_EN
    logic [31:0] stall_ref;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    preload(2, 16'h1234);
    preload(3, 16'hABCD);
    preload(4, 16'h1111);
    preload(5, 16'h2222);

    push(1'b1, 32'hDEADBEEF, 18'd0);
    run(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1);
    push(1'b0, 32'hABCD1234, 18'd2);
    run(1'b1, 1'b0, 32'd1028, 32'h0, 1);
    // rd and wr together behave as a store
    push(1'b1, 32'h55AA33CC, 18'd6);
    run(1'b1, 1'b1, 32'd1036, 32'h55AA33CC, 1);
    push(1'b0, 32'h55AA33CC, 18'd6);
    run(1'b1, 1'b0, 32'd1039, 32'h0, 1);

    // Load held through DONE and the following IDLE: exactly two accesses.
    repeat (2) @(posedge clk);
    done_ref = done_cnt;
`ifdef SRAM_CTRL_STALL_CNT_EN
    stall_ref = stall_count;
`endif
    push(1'b0, 32'hDEADBEEF, 18'd0);
    push(1'b0, 32'hDEADBEEF, 18'd0);
    run(1'b1, 1'b0, 32'd1024, 32'h0, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("held_access_count", 32'(done_cnt - done_ref), 32'd2);
    chk("idle_ready", 32'(ready), 32'd1);
`ifdef SRAM_CTRL_STALL_CNT_EN
    chk("stall_count", stall_count - stall_ref, 32'd14);
`endif

    // Reset pulse at the first HI cycle of a store: low half written, high half kept.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
    chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(1'b0, 32'h2222F00D, 18'd4);
    run(1'b1, 1'b0, 32'd1032, 32'h0, 1);

    // Address below BASE_ADDR wraps modulo 2^32.
    push(1'b1, 32'h0BADC0DE, 18'h3FE00);
    run(1'b0, 1'b1, 32'd0, 32'h0BADC0DE, 1);
    push(1'b0, 32'h0BADC0DE, 18'h3FE00);
    run(1'b1, 1'b0, 32'd0, 32'h0, 1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
